// File: rtl/fetch_sequencer_if.sv
// Control interface between the instruction fetch sequencer and the datapath/execute side.
// The fetch_fault signal exists only when FETCH_TIMEOUT_EN is defined.
interface fetch_sequencer_if;
  logic       run;
  logic       mem_ready;
  logic       exec_done;

  logic       PCout;
  logic       MARin;
  logic       IncPC;
  logic       Zin;
  logic       Zlowout;
  logic       PCin;
  logic       Read;
  logic       Mdatain;
  logic       MDRin;
  logic       MDRout;
  logic       IRin;
  logic       exec_start;
  logic       halted;
  logic [2:0] step;
`ifdef FETCH_TIMEOUT_EN
  logic       fetch_fault;
`endif

  modport master (
    input  run, mem_ready, exec_done,
    output PCout, MARin, IncPC, Zin,
    output Zlowout, PCin, Read, Mdatain, MDRin,
    output MDRout, IRin,
    output exec_start, halted, step
`ifdef FETCH_TIMEOUT_EN
    , output fetch_fault
`endif
  );

  modport slave (
    output run, mem_ready, exec_done,
    input  PCout, MARin, IncPC, Zin,
    input  Zlowout, PCin, Read, Mdatain, MDRin,
    input  MDRout, IRin,
    input  exec_start, halted, step
`ifdef FETCH_TIMEOUT_EN
    , input fetch_fault
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Moore fetch sequencer: IDLE -> T0 -> T1 (memory wait) -> T2 -> EXEC, all outputs registered.
// Optional FETCH_TIMEOUT_EN adds an 8-bit T1 wait counter and a sticky fetch_fault output.
module fetch_sequencer (
  input  logic              clk,
  input  logic              reset_n,
  fetch_sequencer_if.master bus
);

  localparam int unsigned STEP_W = 3;

  typedef enum logic [STEP_W-1:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    EXEC = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic pc_out_q,  pc_out_d;
  logic mar_in_q,  mar_in_d;
  logic inc_pc_q,  inc_pc_d;
  logic z_in_q,    z_in_d;
  logic zlow_out_q, zlow_out_d;
  logic pc_in_q,   pc_in_d;
  logic read_q,    read_d;
  logic mdata_in_q, mdata_in_d;
  logic mdr_in_q,  mdr_in_d;
  logic mdr_out_q, mdr_out_d;
  logic ir_in_q,   ir_in_d;
  logic exec_start_q, exec_start_d;
  logic halted_q,  halted_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned            WAIT_W   = 8;
  localparam logic [WAIT_W-1:0]      WAIT_MAX = '1;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              fault_q,    fault_d;
`endif

  // Next state, then outputs derived from the next state so they line up with state_q
  always_comb begin
    state_d      = state_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    fault_d      = fault_q;
`endif

    case (state_q)
      IDLE: if (bus.run) state_d = T0;
      T0:   state_d = T1;
      T1: begin
        if (bus.mem_ready) begin
          state_d = T2;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == WAIT_MAX) begin
            state_d = IDLE;
            fault_d = 1'b1;
          end
`endif
        end
      end
      T2:   state_d = EXEC;
      EXEC: if (bus.exec_done) state_d = bus.run ? T0 : IDLE;
      default: state_d = IDLE;
    endcase

`ifdef FETCH_TIMEOUT_EN
    if (state_d != T1) wait_cnt_d = '0;
`endif

    pc_out_d     = (state_d == T0);
    mar_in_d     = (state_d == T0);
    inc_pc_d     = (state_d == T0);
    z_in_d       = (state_d == T0);
    zlow_out_d   = (state_d == T1);
    // PCin only on the T0->T1 transition, not on wait cycles
    pc_in_d      = (state_d == T1) && (state_q == T0);
    read_d       = (state_d == T1);
    mdata_in_d   = (state_d == T1);
    mdr_in_d     = (state_d == T1);
    mdr_out_d    = (state_d == T2);
    ir_in_d      = (state_d == T2);
    exec_start_d = (state_d == EXEC) && (state_q == T2);
    halted_d     = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_out_q     <= 1'b0;
      mar_in_q     <= 1'b0;
      inc_pc_q     <= 1'b0;
      z_in_q       <= 1'b0;
      zlow_out_q   <= 1'b0;
      pc_in_q      <= 1'b0;
      read_q       <= 1'b0;
      mdata_in_q   <= 1'b0;
      mdr_in_q     <= 1'b0;
      mdr_out_q    <= 1'b0;
      ir_in_q      <= 1'b0;
      exec_start_q <= 1'b0;
      halted_q     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q   <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_out_q     <= pc_out_d;
      mar_in_q     <= mar_in_d;
      inc_pc_q     <= inc_pc_d;
      z_in_q       <= z_in_d;
      zlow_out_q   <= zlow_out_d;
      pc_in_q      <= pc_in_d;
      read_q       <= read_d;
      mdata_in_q   <= mdata_in_d;
      mdr_in_q     <= mdr_in_d;
      mdr_out_q    <= mdr_out_d;
      ir_in_q      <= ir_in_d;
      exec_start_q <= exec_start_d;
      halted_q     <= halted_d;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign bus.PCout      = pc_out_q;
  assign bus.MARin      = mar_in_q;
  assign bus.IncPC      = inc_pc_q;
  assign bus.Zin        = z_in_q;
  assign bus.Zlowout    = zlow_out_q;
  assign bus.PCin       = pc_in_q;
  assign bus.Read       = read_q;
  assign bus.Mdatain    = mdata_in_q;
  assign bus.MDRin      = mdr_in_q;
  assign bus.MDRout     = mdr_out_q;
  assign bus.IRin       = ir_in_q;
  assign bus.exec_start = exec_start_q;
  assign bus.halted     = halted_q;
  assign bus.step       = STEP_W'(state_q);
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_fault = fault_q;
`endif

endmodule
